wb_interconnect_1xn_reg: RTL and testbench



---
 rtl/wb_interconnect_1xn_reg.sv | 186 ++++++++++++++++++
 tb/tb_wb_interconnect_1xn_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_1xn_reg.sv
// Single-master, N-slave Wishbone classic interconnect with registered request and response paths.
// Base/limit address decode, an ERR reply for unmapped addresses, and a watchdog ERR for hung slaves.
module wb_interconnect_1xn_reg #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_SLAVES       = 4,
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_BASE  = '0,
    parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_LIMIT = '0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [WB_ADDR_WIDTH-1:0]                m_adr,
    input  logic [WB_DATA_WIDTH-1:0]                m_dat_w,
    input  logic [WB_DATA_WIDTH/8-1:0]              m_sel,
    input  logic [2:0]                              m_cti,
    input  logic [1:0]                              m_bte,
    input  logic                                    m_cyc,
    input  logic                                    m_stb,
    input  logic                                    m_we,
    output logic [WB_DATA_WIDTH-1:0]                m_dat_r,
    output logic                                    m_ack,
    output logic                                    m_err,
    output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]       s_adr,
    output logic [N_SLAVES*WB_DATA_WIDTH-1:0]       s_dat_w,
    output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0]   s_sel,
    output logic [N_SLAVES*3-1:0]                   s_cti,
    output logic [N_SLAVES*2-1:0]                   s_bte,
    output logic [N_SLAVES-1:0]                     s_cyc,
    output logic [N_SLAVES-1:0]                     s_stb,
    output logic [N_SLAVES-1:0]                     s_we,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]       s_dat_r,
    input  logic [N_SLAVES-1:0]                     s_ack,
    input  logic [N_SLAVES-1:0]                     s_err,
    output logic                                    unmapped_o,
    output logic                                    timeout_o
);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP_ACK, RESP_ERR} state_t;

    state_t          state_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_w_q;
    logic [SW-1:0]   sel_q;
    logic [2:0]      cti_q;
    logic [1:0]      bte_q;
    logic            we_q;
    logic [IW-1:0]   idx_q;
    logic            cyc_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   m_dat_r_q;
    logic            m_ack_q;
    logic            m_err_q;
    logic            unmapped_q;
    logic            timeout_q;

    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic            sel_ack;
    logic            sel_err;
    logic [DW-1:0]   sel_dat;

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (m_adr >= ADDR_BASE[i*AW +: AW] && m_adr <= ADDR_LIMIT[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_ack = s_ack[i];
                sel_err = s_err[i];
                sel_dat = s_dat_r[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            dat_w_q    <= '0;
            sel_q      <= '0;
            cti_q      <= '0;
            bte_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            cyc_q      <= 1'b0;
            cnt_q      <= '0;
            m_dat_r_q  <= '0;
            m_ack_q    <= 1'b0;
            m_err_q    <= 1'b0;
            unmapped_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            m_ack_q    <= 1'b0;
            m_err_q    <= 1'b0;
            unmapped_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_cyc && m_stb) begin
                        if (hit) begin
                            adr_q   <= m_adr;
                            dat_w_q <= m_dat_w;
                            sel_q   <= m_sel;
                            cti_q   <= m_cti;
                            bte_q   <= m_bte;
                            we_q    <= m_we;
                            idx_q   <= hit_idx;
                            cyc_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end else begin
                            unmapped_q <= 1'b1;
                            m_err_q    <= 1'b1;
                            state_q    <= RESP_ERR;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + CW'(1);
                    if (sel_err) begin
                        m_dat_r_q <= sel_dat;
                        cyc_q     <= 1'b0;
                        m_err_q   <= 1'b1;
                        state_q   <= RESP_ERR;
                    end else if (sel_ack) begin
                        m_dat_r_q <= sel_dat;
                        cyc_q     <= 1'b0;
                        m_ack_q   <= 1'b1;
                        state_q   <= RESP_ACK;
                    end else if (TO_EN && cnt_q == CNT_LAST) begin
                        cyc_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        m_err_q   <= 1'b1;
                        state_q   <= RESP_ERR;
                    end else if (!m_cyc) begin
                        cyc_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RESP_ACK: state_q <= IDLE;
                RESP_ERR: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign m_dat_r    = m_dat_r_q;
    assign m_ack      = m_ack_q;
    assign m_err      = m_err_q;
    assign unmapped_o = unmapped_q;
    assign timeout_o  = timeout_q;

    // Request fields fan out to every lane; only cyc/stb carry the selection.
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_lane
        localparam logic [IW-1:0] LANE = IW'(i);
        assign s_adr[i*AW +: AW]   = adr_q;
        assign s_dat_w[i*DW +: DW] = dat_w_q;
        assign s_sel[i*SW +: SW]   = sel_q;
        assign s_cti[i*3 +: 3]     = cti_q;
        assign s_bte[i*2 +: 2]     = bte_q;
        assign s_we[i]             = we_q;
        assign s_cyc[i]            = cyc_q && (idx_q == LANE);
        assign s_stb[i]            = cyc_q && (idx_q == LANE);
    end

endmodule

// File: tb/tb_wb_interconnect_1xn_reg.sv
// Bench for wb_interconnect_1xn_reg: directed vector table, randomized vectors scored by an
// address-map/latency model, and hand sequences for master abort and mid-transfer reset.
module tb_wb_interconnect_1xn_reg;
    localparam int N  = 3;
    localparam int TO = 16;
    localparam int MODE_ACK = 0, MODE_ERR = 1, MODE_BOTH = 2, MODE_NEVER = 3;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] m_adr, m_dat_w, m_dat_r;
    logic [3:0]  m_sel;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic        m_cyc, m_stb, m_we, m_ack, m_err;
    logic [N*32-1:0] s_adr, s_dat_w, s_dat_r;
    logic [N*4-1:0]  s_sel;
    logic [N*3-1:0]  s_cti;
    logic [N*2-1:0]  s_bte;
    logic [N-1:0]    s_cyc, s_stb, s_we, s_ack, s_err;
    logic            unmapped_o, timeout_o;

    wb_interconnect_1xn_reg #(
        .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_SLAVES(N),
        .ADDR_BASE ({32'h0000_1800, 32'h0000_1000, 32'h0000_0000}),
        .ADDR_LIMIT({32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF}),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .unmapped_o(unmapped_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        int          mode;
        int          waits;
        logic [31:0] rdat;
        int          exp_lane;
        int          exp_lat;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_dat;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] base_a [N] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_1800};
    logic [31:0] limit_a[N] = '{32'h0000_0FFF, 32'h0000_1FFF, 32'h0000_2FFF};
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                                input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                                input int mode, input int waits, input logic [31:0] rdat,
                                input int lane, input int lat, input logic err, input logic to,
                                input logic [31:0] dat);
        vec_t v;
        v.adr = adr; v.we = we; v.wdat = wdat; v.sel = sel; v.cti = cti; v.bte = bte;
        v.mode = mode; v.waits = waits; v.rdat = rdat;
        v.exp_lane = lane; v.exp_lat = lat; v.exp_err = err; v.exp_to = to; v.exp_dat = dat;
        return v;
    endfunction

    // Reference: first range containing the address wins; a slave that has not answered
    // within TO strobe cycles is cut off by the watchdog.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_lane = -1;
        for (int i = 0; i < N; i++)
            if (r.exp_lane < 0 && v.adr >= base_a[i] && v.adr <= limit_a[i]) r.exp_lane = i;
        r.exp_to = 1'b0;
        r.exp_dat = v.rdat;
        if (r.exp_lane < 0) begin
            r.exp_lat = 1; r.exp_err = 1'b1;
        end else if (v.mode == MODE_NEVER || v.waits >= TO) begin
            r.exp_lat = TO + 1; r.exp_err = 1'b1; r.exp_to = 1'b1;
        end else begin
            r.exp_lat = 2 + v.waits; r.exp_err = (v.mode != MODE_ACK);
        end
        return r;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        int stb_cnt[N];
        int lat = 0, to_cnt = 0, um_cnt = 0, t = v.exp_lane, exp_stb;
        bit done = 0, fld_ok = 1;
        logic got_ack = 0, got_err = 0;
        logic [31:0] got_dat = '0;
        for (int k = 0; k < N; k++) stb_cnt[k] = 0;
        s_ack = '0; s_err = '0;
        for (int k = 0; k < N; k++) s_dat_r[k*32 +: 32] = (t == k) ? v.rdat : $urandom;
        m_adr = v.adr; m_we = v.we; m_dat_w = v.wdat; m_sel = v.sel; m_cti = v.cti; m_bte = v.bte;
        m_cyc = 1'b1; m_stb = 1'b1;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < N; k++) if (s_stb[k]) stb_cnt[k]++;
            if (timeout_o) to_cnt++;
            if (unmapped_o) um_cnt++;
            if (t >= 0 && s_stb[t]) begin
                if (s_adr[t*32 +: 32] !== v.adr || s_dat_w[t*32 +: 32] !== v.wdat ||
                    s_sel[t*4 +: 4] !== v.sel || s_cti[t*3 +: 3] !== v.cti ||
                    s_bte[t*2 +: 2] !== v.bte || s_we[t] !== v.we || s_cyc[t] !== 1'b1)
                    fld_ok = 0;
            end
            if (m_ack || m_err) begin
                lat = c; got_ack = m_ack; got_err = m_err; got_dat = m_dat_r; done = 1;
                m_cyc = 1'b0; m_stb = 1'b0;
            end
            s_ack = N'($urandom); s_err = N'($urandom);
            if (t >= 0) begin
                s_ack[t] = 1'b0; s_err[t] = 1'b0;
                if (!done && s_stb[t] && stb_cnt[t] == v.waits + 1) begin
                    s_ack[t] = (v.mode == MODE_ACK || v.mode == MODE_BOTH);
                    s_err[t] = (v.mode == MODE_ERR || v.mode == MODE_BOTH);
                end
            end
        end
        chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({nm, " m_err"}, 64'(got_err), 64'(v.exp_err));
        chk({nm, " m_ack"}, 64'(got_ack), 64'(!v.exp_err));
        if (!v.exp_err) chk({nm, " m_dat_r"}, 64'(got_dat), 64'(v.exp_dat));
        for (int k = 0; k < N; k++) begin
            exp_stb = (k != t) ? 0 : (v.exp_to ? TO : v.waits + 1);
            chk($sformatf("%s stb_cycles[%0d]", nm, k), 64'(stb_cnt[k]), 64'(exp_stb));
        end
        chk({nm, " fields"}, 64'(fld_ok), 64'd1);
        chk({nm, " unmapped_pulses"}, 64'(um_cnt), 64'(t < 0));
        chk({nm, " timeout_pulses"}, 64'(to_cnt), 64'(v.exp_to));
        @(posedge clk); @(negedge clk);
        chk({nm, " resp_one_cycle"}, {62'd0, m_ack, m_err}, 64'd0);
        chk({nm, " idle_cyc"}, 64'(s_cyc), 64'd0);
        if (!v.exp_err) chk({nm, " m_dat_r_hold"}, 64'(m_dat_r), 64'(v.exp_dat));
        chk({nm, " pulses_clear"}, {62'd0, unmapped_o, timeout_o}, 64'd0);
    endtask

    task automatic start_stuck(input logic [31:0] adr);
        s_ack = '0; s_err = '0;
        m_adr = adr; m_we = 1'b0; m_dat_w = '0; m_sel = 4'hF; m_cti = '0; m_bte = '0;
        m_cyc = 1'b1; m_stb = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t v;
        rst = 1'b1;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_cti = '0; m_bte = '0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        s_dat_r = '0; s_ack = '0; s_err = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst m_ack/m_err/pulses", {60'd0, m_ack, m_err, unmapped_o, timeout_o}, 64'd0);
        chk("rst m_dat_r", 64'(m_dat_r), 64'd0);
        chk("rst s_req", {57'd0, |s_adr, |s_dat_w, |s_sel, |s_cti, |s_bte, |s_we, |s_cyc}, 64'd0);
        chk("rst s_stb", 64'(s_stb), 64'd0);
        rst = 1'b0;

        tbl.push_back(mk(32'h0000_0010, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_ACK, 0, 32'hDEADBEEF, 0, 2, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(32'h0000_1804, 1, 32'hA5A5A5A5, 4'hF, 3'd0, 2'd0, MODE_ACK, 0, 32'h0, 1, 2, 0, 0, 32'h0));
        tbl.push_back(mk(32'h0000_4000, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_ACK, 0, 32'h0, -1, 1, 1, 0, 32'h0));
        tbl.push_back(mk(32'h0000_2000, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_NEVER, 0, 32'h0, 2, 17, 1, 1, 32'h0));
        tbl.push_back(mk(32'h0000_0800, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_BOTH, 0, 32'h11112222, 0, 2, 1, 0, 32'h0));
        tbl.push_back(mk(32'h0000_0FFF, 0, 32'h0, 4'h1, 3'd0, 2'd0, MODE_ACK, 1, 32'hCAFE0001, 0, 3, 0, 0, 32'hCAFE0001));
        tbl.push_back(mk(32'h0000_1000, 1, 32'h1234_5678, 4'h3, 3'd7, 2'd0, MODE_ACK, 3, 32'h0, 1, 5, 0, 0, 32'h0));
        tbl.push_back(mk(32'h0000_17FF, 0, 32'h0, 4'hF, 3'b010, 2'd1, MODE_ACK, 0, 32'h600DF00D, 1, 2, 0, 0, 32'h600DF00D));
        tbl.push_back(mk(32'h0000_2FFF, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_ACK, 15, 32'h0BADC0DE, 2, 17, 0, 0, 32'h0BADC0DE));
        tbl.push_back(mk(32'h0000_3000, 1, 32'hFFFF_0000, 4'hF, 3'd0, 2'd0, MODE_ACK, 0, 32'h0, -1, 1, 1, 0, 32'h0));
        tbl.push_back(mk(32'h0000_2800, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_ERR, 2, 32'h0, 2, 4, 1, 0, 32'h0));
        tbl.push_back(mk(32'hFFFF_FFFF, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_ACK, 0, 32'h0, -1, 1, 1, 0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("dir%0d", i));

        for (int i = 0; i < 60; i++) begin
            int r;
            v.adr   = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 32'h3FFF)) : 32'($urandom);
            v.we    = 1'($urandom); v.wdat = $urandom; v.sel = 4'($urandom);
            v.cti   = 3'($urandom); v.bte = 2'($urandom); v.rdat = $urandom;
            r = $urandom_range(0, 9);
            v.mode  = (r < 6) ? MODE_ACK : (r < 8) ? MODE_ERR : (r < 9) ? MODE_BOTH : MODE_NEVER;
            v.waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
            apply(model(v), $sformatf("rnd%0d", i));
        end

        // Master abort in the third BUSY cycle: strobe drops, nothing comes back.
        start_stuck(32'h0000_0040);
        chk("abort s_cyc_before", 64'(s_cyc), 64'b001);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort s_cyc_after", 64'({s_cyc, s_stb}), 64'd0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("abort no_resp", {62'd0, m_ack, m_err}, 64'd0);
        end

        // Reset in the third BUSY cycle clears everything, including held read data.
        start_stuck(32'h0000_2400);
        chk("rst_mid s_cyc_before", 64'(s_cyc), 64'b100);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_mid outs", {57'd0, m_ack, m_err, unmapped_o, timeout_o, |s_cyc, |s_stb, |s_we}, 64'd0);
        chk("rst_mid m_dat_r", 64'(m_dat_r), 64'd0);
        chk("rst_mid s_req", {60'd0, |s_adr, |s_sel, |s_cti, |s_bte}, 64'd0);
        rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_mid no_resp", {61'd0, m_ack, m_err, |s_cyc}, 64'd0);
        end
        apply(mk(32'h0000_1FFC, 0, 32'h0, 4'hF, 3'd0, 2'd0, MODE_ACK, 0, 32'h7777_1111, 1, 2, 0, 0, 32'h7777_1111), "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
